// File: rtl/adder_subtractor.sv
// -----------------------------------------------------------------------------
// adder_subtractor
//
// An n-bit two's-complement adder/subtractor with a registered result stage.
// It computes x+y or x-y from a single mode bit. Carry-out and signed overflow
// appear one clock later. Subtraction reuses the add chain: y is inverted
// bit-wise and the mode bit is fed in as the carry-in, so x + ~y + 1 = x - y.
//
// Parameters
//   n          operand/result width in bits (n >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all outputs
//   x          operand A
//   y          operand B
//   add_n      mode: 0 = add (x+y), 1 = subtract (x-y)
//   in_valid   capture x/y/add_n on this edge when high
//   s          registered result, low n bits (wraps modulo 2^n)
//   C_out      registered carry out of bit n-1 (subtract: 1 = no borrow)
//   overflow   registered signed-overflow flag
//   out_valid  high for one cycle after each accepted operation
// -----------------------------------------------------------------------------
module adder_subtractor #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  input  logic         in_valid,
  output logic [n-1:0] s,
  output logic         C_out,
  output logic         overflow,
  output logic         out_valid
);

  // Conditionally inverted operand B, ripple sum and carry chain.
  // c[i] is the carry into bit i; c[n] is the carry out of the MSB.
  logic [n-1:0] b_eff;
  logic [n-1:0] sum;
  logic [n:0]   c;

  // Carry-in equals the mode bit: completes the two's-complement negation of y.
  assign c[0] = add_n;

  // Ripple chain of full-adder cells, one per bit.
  for (genvar i = 0; i < n; i++) begin : g_fa
    logic p;  // propagate term for this cell

    assign b_eff[i]  = y[i] ^ add_n;
    assign p         = x[i] ^ b_eff[i];
    assign sum[i]    = p ^ c[i];
    assign c[i + 1]  = (x[i] & b_eff[i]) | (c[i] & p);
  end

  // Signed overflow: the carry into the sign bit differs from the carry out.
  logic overflow_d;
  assign overflow_d = c[n] ^ c[n-1];

  // Result register. Outputs hold between accepted operations; only out_valid
  // tracks in_valid every cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s         <= '0;
      C_out     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s        <= sum;
        C_out    <= c[n];
        overflow <= overflow_d;
      end
    end
  end

endmodule

// File: tb/tb_adder_subtractor.sv
// -----------------------------------------------------------------------------
// tb_adder_subtractor
//
// Self-checking bench for adder_subtractor (n = 4). Directed vectors come from
// a table of {inputs, expected outputs}; random back-to-back traffic takes its
// expectations from an arithmetic reference model. Every accepted operation
// pushes its expected result to a queue, popped when out_valid is seen.
// Hand-written sequences cover hold, asynchronous reset and capture-in-reset.
// -----------------------------------------------------------------------------
module tb_adder_subtractor;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         ov;
  } exp_t;

  typedef struct {
    string        name;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         sub;
    exp_t         e;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         add_n;
  logic         in_valid;
  logic [N-1:0] s;
  logic         C_out;
  logic         overflow;
  logic         out_valid;

  int   n_cmp;
  int   n_fail;
  exp_t q[$];
  exp_t held;

  adder_subtractor #(.n(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .x         (x),
    .y         (y),
    .add_n     (add_n),
    .in_valid  (in_valid),
    .s         (s),
    .C_out     (C_out),
    .overflow  (overflow),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model from integer arithmetic: unsigned sum for carry,
  // signed result range for overflow.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
    exp_t r;
    int   ua, ub, u, sa, sb, sr;
    ua = int'(a);
    ub = int'(b);
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      u  = ua + ((~ub) & ((1 << N) - 1)) + 1;
      sr = sa - sb;
    end else begin
      u  = ua + ub;
      sr = sa + sb;
    end
    r.s  = u[N-1:0];
    r.c  = u[N];
    r.ov = (sr > (1 << (N - 1)) - 1) || (sr < -(1 << (N - 1)));
    return r;
  endfunction

  // One clock of stimulus: drive on the falling edge, sample 1 ns after the
  // rising edge, and compare against the scoreboard or the held values.
  task automatic cycle(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic sub, input logic v, input exp_t e);
    exp_t got;
    @(negedge clk);
    x        = a;
    y        = b;
    add_n    = sub;
    in_valid = v;
    if (v) q.push_back(e);
    @(posedge clk);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s.scoreboard: got out_valid=1, expected empty queue to stay idle", tag);
      end else begin
        got  = q.pop_front();
        check({tag, ".s"},        32'(s),        32'(got.s));
        check({tag, ".C_out"},    32'(C_out),    32'(got.c));
        check({tag, ".overflow"}, 32'(overflow), 32'(got.ov));
        held = got;
      end
    end else begin
      check({tag, ".hold_s"},        32'(s),        32'(held.s));
      check({tag, ".hold_C_out"},    32'(C_out),    32'(held.c));
      check({tag, ".hold_overflow"}, 32'(overflow), 32'(held.ov));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".s"},         32'(s),         32'd0);
    check({tag, ".C_out"},     32'(C_out),     32'd0);
    check({tag, ".overflow"},  32'(overflow),  32'd0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[7];
  exp_t none;

  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    none     = '{s: '0, c: 1'b0, ov: 1'b0};
    held     = none;
    rst_n    = 1'b0;
    x        = '0;
    y        = '0;
    add_n    = 1'b0;
    in_valid = 1'b0;

    vecs[0] = '{"add_ovf",     4'd5,    4'd6,    1'b0, '{4'b1011, 1'b0, 1'b1}};
    vecs[1] = '{"sub_neg",     4'd5,    4'd6,    1'b1, '{4'b1111, 1'b0, 1'b0}};
    vecs[2] = '{"sub_ovf",     4'd7,    4'b1010, 1'b1, '{4'b1101, 1'b0, 1'b1}};
    vecs[3] = '{"sub_negs",    4'b1100, 4'b1110, 1'b1, '{4'b1110, 1'b0, 1'b0}};
    vecs[4] = '{"add_neg_ovf", 4'b1000, 4'b1000, 1'b0, '{4'b0000, 1'b1, 1'b1}};
    vecs[5] = '{"sub_zero",    4'd0,    4'd0,    1'b1, '{4'b0000, 1'b1, 1'b0}};
    vecs[6] = '{"add_wrap",    4'b1111, 4'b0001, 1'b0, '{4'b0000, 1'b1, 1'b0}};

    // Reset state, before any clock edge and after a few.
    #1;
    check_zero("reset_t0");
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset_held");

    @(negedge clk);
    rst_n = 1'b1;

    // Directed table, back to back; the last entry is the carry-no-overflow case.
    for (int i = 0; i < 7; i++)
      cycle(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].sub, 1'b1, vecs[i].e);

    // Hold: three idle cycles with changing operands and mode.
    cycle("hold0", 4'd5,    4'd3, 1'b0, 1'b0, none);
    cycle("hold1", 4'b1010, 4'd7, 1'b1, 1'b0, none);
    cycle("hold2", 4'd7,    4'd7, 1'b0, 1'b0, none);

    // Load 1011, idle one cycle, then pulse rst_n low between edges.
    cycle("pre_rst", 4'd5, 4'd6, 1'b0, 1'b1, model(4'd5, 4'd6, 1'b0));
    cycle("pre_rst_idle", 4'd0, 4'd0, 1'b0, 1'b0, none);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    #1;
    rst_n = 1'b1;
    held  = none;
    cycle("after_rst", 4'd3, 4'd3, 1'b1, 1'b1, '{4'b0000, 1'b1, 1'b0});

    // Capture attempted while reset is held: must be discarded.
    @(negedge clk);
    rst_n    = 1'b0;
    x        = 4'd5;
    y        = 4'd6;
    add_n    = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_zero("capture_in_rst");
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    held     = none;

    // Random back-to-back traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] a, b;
      logic         sub, v;
      a   = N'($urandom_range(0, (1 << N) - 1));
      b   = N'($urandom_range(0, (1 << N) - 1));
      sub = 1'($urandom_range(0, 1));
      v   = ($urandom_range(0, 3) != 0);
      cycle($sformatf("rand%0d", i), a, b, sub, v, model(a, b, sub));
    end

    check("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_subtractor.md
# adder_subtractor

Parameterised n-bit two's-complement adder/subtractor with a registered result stage. Computes x+y or x−y from a single mode bit and reports carry-out and signed overflow one clock later. Used as the arithmetic leaf in datapaths that need both operations from one carry chain. Internally it is a ripple-carry chain of full-adder cells, with y conditionally inverted and carry-in driven by the mode bit.

## Interface
- Clocking: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Parameter `n`, default 4: operand and result width in bits (n ≥ 2).
- `clk` input, 1 bit: rising-edge clock.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `x` input, n bits: operand A (two's complement / unsigned).
- `y` input, n bits: operand B.
- `add_n` input, 1 bit: mode select.
  - 0 = add (x+y).
  - 1 = subtract (x−y).
- `in_valid` input, 1 bit: operands and mode are captured on this edge when high.
- `s` output, n bits: registered result, low n bits.
- `C_out` output, 1 bit: registered carry out of bit n−1.
- `overflow` output, 1 bit: registered signed-overflow flag.
- `out_valid` output, 1 bit: high for one cycle after each accepted operation.

## Operation
- Operand B path: b_eff[i] = y[i] XOR add_n for every bit. The chain's carry-in c[0] = add_n.
- Ripple chain: for i = 0..n−1:
  - sum[i] = x[i] ^ b_eff[i] ^ c[i]
  - c[i+1] = x[i]&b_eff[i] | c[i]&(x[i]^b_eff[i])
- The chain is built as a generate loop of full-adder cells; there is no behavioural `+`.
- Flags:
  - C_out = c[n].
  - In subtract mode, C_out = 1 means no borrow (x ≥ y unsigned).
  - overflow = c[n] XOR c[n−1]; it is set when the signed result is outside [−2^(n−1), 2^(n−1)−1].
- Result wraps modulo 2^n. There is no saturation.
- Registered stage: on a rising clk edge with in_valid=1, s, C_out and overflow load the combinational results and out_valid←1.
- On an edge with in_valid=0, s, C_out and overflow hold their values and out_valid←0.
- Only the add_n value present at the capturing edge matters. Mode changes between edges have no effect.

## Timing
- Latency: exactly one cycle. Inputs sampled at edge k appear on the outputs after edge k and stay stable until the next accepted edge.
- Throughput: one operation per cycle. Back-to-back in_valid is fully supported with no bubbles.
- Reset: rst_n low immediately forces s=0, C_out=0, overflow=0, out_valid=0, independent of clk.
- Reset deassertion: the first capture occurs on the first rising edge with rst_n high and in_valid high.
- Reset mid-operation: an operation captured on the same edge that reset asserts is discarded. No output is produced for it.
- The combinational path from x/y/add_n to the register D inputs must close timing in one clk period for the chosen n.

## Test plan
- Add with signed overflow: n=4, x=5, y=6, add_n=0, in_valid=1 → next cycle s=4'b1011 (11), C_out=0, overflow=1, out_valid=1.
- Subtract, negative result: x=5, y=6, add_n=1 → s=4'b1111 (−1), C_out=0 (borrow), overflow=0.
- Subtract with signed overflow: x=7, y=4'b1010 (−6), add_n=1 → s=4'b1101, C_out=0, overflow=1.
- Subtract of two negatives: x=4'b1100 (−4), y=4'b1110 (−2), add_n=1 → s=4'b1110 (−2), C_out=0, overflow=0.
- Carry without overflow plus hold behaviour:
  - x=4'b1111, y=4'b0001, add_n=0 → s=0, C_out=1, overflow=0.
  - Then in_valid=0 for 3 cycles with changing x/y → s, C_out and overflow hold, out_valid=0.
- Asynchronous reset mid-stream: with s=4'b1011 held, pulse rst_n low between clock edges → s, C_out, overflow and out_valid go to 0 immediately.
  - After release, x=3, y=3, add_n=1 → s=0, C_out=1, overflow=0.
